elevator_call_scheduler: RTL and testbench
==========================================

Name: elevator_call_scheduler

Overview:
Parametrised SCAN (sweep) scheduler for the elevator controller. Replaces the single-entry "insert before memory head" comparison with a registered per-floor hall-call bitmap. It tracks travel direction and selects the nearest pending floor ahead. It drives motor direction and door dwell, and flags when a new call preempts the current target on the way.

Parameters:
FLOORS, 4, number of floors (2..64); floors are numbered 0..FLOORS-1.
FLOOR_W, 2, width of floor fields; must satisfy 2**FLOOR_W >= FLOORS.
DWELL_CYCLES, 8, number of clock cycles the door stays open per stop (>=1).

Ports:
clk  in  1  system clock; everything is rising-edge.
rst_n  in  1  asynchronous, active-low reset.
call_valid  in  1  one-cycle call strobe.
call_floor  in  FLOOR_W  floor of the call.
call_dir  in  1  1 = up request, 0 = down request.
actual_floor  in  FLOOR_W  current cabin floor from the position sensor.
floor_strobe  in  1  one-cycle pulse when the cabin is level with actual_floor.
target_floor  out  FLOOR_W  registered current destination.
motor_up  out  1  drive cabin upward.
motor_down  out  1  drive cabin downward.
door_open  out  1  door command.
preempt  out  1  one-cycle pulse: target replaced by a closer floor while moving.
call_err  out  1  one-cycle pulse: call_floor >= FLOORS; the call is dropped.
busy  out  1  high when the state is not IDLE or any call is pending.

Behaviour:
- Reset (asynchronous, any time including mid-move or mid-dwell): state=IDLE, up_req/dn_req bitmaps=0, dir_last=up, dwell counter=0. All outputs are 0.
- Call capture: on a valid, in-range call, up_req[f] or dn_req[f] is set at the next edge. Duplicate calls are no-ops. An out-of-range call sets no bit and pulses call_err for 1 cycle.
- pend[f] = up_req[f] | dn_req[f]. "Ahead up" = the lowest f > actual_floor with pend set. "Ahead down" = the highest f < actual_floor with pend set.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR. Exactly one of motor_up, motor_down, door_open is high at a time. All three are low in IDLE.
- IDLE transitions:
  - pend[actual_floor] set → DOOR.
  - Else a call exists ahead in dir_last → move that way.
  - Else a call exists in the opposite direction → move that way and flip dir_last.
  - Else stay in IDLE.
- MOVE_UP / MOVE_DOWN: target_floor = nearest pending floor ahead, re-evaluated every cycle. If a newly captured call lies strictly between actual_floor and the registered target in the travel direction, target_floor updates on the next edge and preempt pulses in that same cycle. A farther call never pulses preempt.
- Arrival: floor_strobe && actual_floor == target_floor → DOOR on the next edge. Both up_req and dn_req at that floor are cleared, and the dwell counter is loaded with DWELL_CYCLES-1. floor_strobe at a non-target floor is ignored.
- DOOR: door_open=1 and the counter decrements each cycle.
  - A call for actual_floor arriving during DOOR is cleared in the same edge (never left pending) and reloads the counter, extending the dwell.
  - At counter==0: a call ahead in dir_last → continue that way. Else a call in the opposite direction → reverse and flip dir_last. Else → IDLE.
- Simultaneous events: a call and a clear for the same floor in the same edge → clear wins. Calls for other floors are captured normally in any state.
- Latency: call to motor command is 1 cycle from IDLE. floor_strobe to door_open is 1 cycle.
- Widths: floor comparisons are unsigned at FLOOR_W. Search is combinational over FLOORS bits with no wrap-around: floor 0 has no "down" and floor FLOORS-1 has no "up".

Optional Feature:
Macro ELEV_FIRE_RECALL_EN.
- Defined:
  - Adds input port fire_recall (1 bit, level).
  - While fire_recall is high: all bitmaps are cleared, new calls are ignored, target_floor=0, and the scheduler drives MOVE_DOWN until it arrives at floor 0.
  - At floor 0, door_open is held high indefinitely with no dwell countdown.
  - When fire_recall deasserts: go to IDLE with empty bitmaps.
  - Recall overrides DOOR and MOVE_UP immediately, on the next edge.
- Not defined: the port is absent and the behaviour is exactly as above.

Test Plan:
- Reset: rst_n low mid-MOVE_UP → all outputs 0 asynchronously. After release with no calls, busy stays 0.
- Basic trip (FLOORS=4, DWELL=4, actual=0): up call at 3 → motor_up next cycle, target=3. floor_strobe at 3 → door_open for exactly 4 cycles, then IDLE.
- Preempt: moving up from 0 to target 3, up call at 2 → target=2 with one preempt pulse. Stop at 2, then continue to 3. A call at 3 while target=2 gives no pulse.
- Reversal: at 2 moving up with pending down call at 0 only → after dwell, motor_down and target=0.
- Boundaries: call_floor=5 with FLOORS=4, FLOOR_W=3 → call_err pulse, no state change. Call at the current floor during DOOR → dwell restarts and the bit is never visible as pending.
- Fire recall (macro on): at floor 2 in DOOR with calls at 3, assert fire_recall → motor_down, bitmaps 0. Arrive at 0 → door_open held. Deassert → IDLE.

Source files
------------

// File: rtl/elevator_call_scheduler_if.sv
// Call / position / command bundle between the elevator controller and the SCAN scheduler.
// ELEV_FIRE_RECALL_EN adds the fire_recall level input.
interface elevator_call_scheduler_if #(
    parameter int FLOOR_W = 2
);
    logic               call_valid;
    logic [FLOOR_W-1:0] call_floor;
    logic               call_dir;
    logic [FLOOR_W-1:0] actual_floor;
    logic               floor_strobe;
`ifdef ELEV_FIRE_RECALL_EN
    logic               fire_recall;
`endif
    logic [FLOOR_W-1:0] target_floor;
    logic               motor_up;
    logic               motor_down;
    logic               door_open;
    logic               preempt;
    logic               call_err;
    logic               busy;

`ifdef ELEV_FIRE_RECALL_EN
    modport master (
        output call_valid, call_floor, call_dir, actual_floor, floor_strobe, fire_recall,
        input  target_floor, motor_up, motor_down, door_open, preempt, call_err, busy
    );
    modport slave (
        input  call_valid, call_floor, call_dir, actual_floor, floor_strobe, fire_recall,
        output target_floor, motor_up, motor_down, door_open, preempt, call_err, busy
    );
`else
    modport master (
        output call_valid, call_floor, call_dir, actual_floor, floor_strobe,
        input  target_floor, motor_up, motor_down, door_open, preempt, call_err, busy
    );
    modport slave (
        input  call_valid, call_floor, call_dir, actual_floor, floor_strobe,
        output target_floor, motor_up, motor_down, door_open, preempt, call_err, busy
    );
`endif
endinterface

// File: rtl/elevator_call_scheduler.sv
// SCAN elevator scheduler: per-floor up/down hall-call bitmaps, sweep direction, door dwell.
// Optional fire-service recall is compiled in with ELEV_FIRE_RECALL_EN.
module elevator_call_scheduler #(
    parameter int FLOORS       = 4,
    parameter int FLOOR_W      = 2,
    parameter int DWELL_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    elevator_call_scheduler_if.slave   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_UP   = 2'd1;
    localparam logic [1:0] S_DOWN = 2'd2;
    localparam logic [1:0] S_DOOR = 2'd3;

    localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [FLOOR_W:0]   FLOORS_C   = FLOORS[FLOOR_W:0];

    // Lowest pending floor above a (or at a when incl); MSB flags a hit.
    function automatic logic [FLOOR_W:0] find_up(input logic [FLOORS-1:0] p,
                                                 input logic [FLOOR_W-1:0] a,
                                                 input logic incl);
        logic [FLOOR_W:0] r;
        r = '0;
        for (int f = FLOORS - 1; f >= 0; f--) begin
            if (p[f] && ((FLOOR_W'(f) > a) || (incl && (FLOOR_W'(f) == a)))) begin
                r = {1'b1, FLOOR_W'(f)};
            end
        end
        return r;
    endfunction

    // Highest pending floor below a (or at a when incl); MSB flags a hit.
    function automatic logic [FLOOR_W:0] find_dn(input logic [FLOORS-1:0] p,
                                                 input logic [FLOOR_W-1:0] a,
                                                 input logic incl);
        logic [FLOOR_W:0] r;
        r = '0;
        for (int f = 0; f < FLOORS; f++) begin
            if (p[f] && ((FLOOR_W'(f) < a) || (incl && (FLOOR_W'(f) == a)))) begin
                r = {1'b1, FLOOR_W'(f)};
            end
        end
        return r;
    endfunction

    logic [1:0]         state_q, state_d;
    logic [FLOORS-1:0]  up_req_q, up_req_d;
    logic [FLOORS-1:0]  dn_req_q, dn_req_d;
    logic               dir_last_q, dir_last_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [FLOOR_W-1:0] target_q, target_d;
    logic               preempt_q, preempt_d;
    logic               call_err_q, call_err_d;
    logic               motor_up_q, motor_down_q, door_open_q, busy_q;
`ifdef ELEV_FIRE_RECALL_EN
    logic               recall_q, recall_d;
`endif

    logic               in_range_s;
    logic               call_ok_s;
    logic [FLOORS-1:0]  call_hit_s;
    logic [FLOORS-1:0]  act_hot_s;
    logic [FLOORS-1:0]  up_m_s, dn_m_s, pend_m_s;
    logic [FLOOR_W:0]   up_str_s, dn_str_s, up_inc_s, dn_inc_s;
    logic [1:0]         dep_state_s;
    logic               dep_dir_s;
    logic [FLOOR_W-1:0] dep_tgt_s;

    // Decode the incoming call and cabin position into one-hot floor masks.
    always_comb begin
        in_range_s = ({1'b0, bus.call_floor} < FLOORS_C);
`ifdef ELEV_FIRE_RECALL_EN
        call_ok_s  = bus.call_valid && in_range_s && !bus.fire_recall;
`else
        call_ok_s  = bus.call_valid && in_range_s;
`endif
        for (int f = 0; f < FLOORS; f++) begin
            call_hit_s[f] = call_ok_s && (bus.call_floor == FLOOR_W'(f));
            act_hot_s[f]  = (bus.actual_floor == FLOOR_W'(f));
        end
    end

    // Merge this cycle's call so IDLE can launch the motor one cycle after the strobe.
    always_comb begin
        up_m_s   = up_req_q | (bus.call_dir ? call_hit_s : {FLOORS{1'b0}});
        dn_m_s   = dn_req_q | (bus.call_dir ? {FLOORS{1'b0}} : call_hit_s);
        pend_m_s = up_m_s | dn_m_s;
        up_str_s = find_up(pend_m_s, bus.actual_floor, 1'b0);
        dn_str_s = find_dn(pend_m_s, bus.actual_floor, 1'b0);
        up_inc_s = find_up(pend_m_s, bus.actual_floor, 1'b1);
        dn_inc_s = find_dn(pend_m_s, bus.actual_floor, 1'b1);
    end

    // Departure choice shared by IDLE and end of dwell: keep sweeping, else reverse, else rest.
    always_comb begin
        dep_state_s = S_IDLE;
        dep_dir_s   = dir_last_q;
        dep_tgt_s   = target_q;
        if (dir_last_q) begin
            if (up_str_s[FLOOR_W]) begin
                dep_state_s = S_UP;
                dep_tgt_s   = up_str_s[FLOOR_W-1:0];
            end else if (dn_str_s[FLOOR_W]) begin
                dep_state_s = S_DOWN;
                dep_dir_s   = 1'b0;
                dep_tgt_s   = dn_str_s[FLOOR_W-1:0];
            end else begin
                dep_state_s = S_IDLE;
            end
        end else begin
            if (dn_str_s[FLOOR_W]) begin
                dep_state_s = S_DOWN;
                dep_tgt_s   = dn_str_s[FLOOR_W-1:0];
            end else if (up_str_s[FLOOR_W]) begin
                dep_state_s = S_UP;
                dep_dir_s   = 1'b1;
                dep_tgt_s   = up_str_s[FLOOR_W-1:0];
            end else begin
                dep_state_s = S_IDLE;
            end
        end
    end

    // Main next-state logic: FSM, bitmap update, dwell counter, preempt and error pulses.
    always_comb begin
        state_d    = state_q;
        up_req_d   = up_m_s;
        dn_req_d   = dn_m_s;
        dir_last_d = dir_last_q;
        dwell_d    = dwell_q;
        target_d   = target_q;
        preempt_d  = 1'b0;
        call_err_d = bus.call_valid && !in_range_s;
`ifdef ELEV_FIRE_RECALL_EN
        recall_d   = bus.fire_recall;
        if (bus.fire_recall) begin
            call_err_d = 1'b0;
        end else begin
            call_err_d = bus.call_valid && !in_range_s;
        end
`endif
        case (state_q)
            S_IDLE: begin
                if (|(pend_m_s & act_hot_s)) begin
                    state_d  = S_DOOR;
                    up_req_d = up_m_s & ~act_hot_s;
                    dn_req_d = dn_m_s & ~act_hot_s;
                    dwell_d  = DWELL_LOAD;
                    target_d = bus.actual_floor;
                end else begin
                    state_d    = dep_state_s;
                    dir_last_d = dep_dir_s;
                    target_d   = dep_tgt_s;
                end
            end
            S_UP: begin
                if (bus.floor_strobe && (bus.actual_floor == target_q)) begin
                    state_d  = S_DOOR;
                    up_req_d = up_m_s & ~act_hot_s;
                    dn_req_d = dn_m_s & ~act_hot_s;
                    dwell_d  = DWELL_LOAD;
                end else begin
                    if (up_inc_s[FLOOR_W]) begin
                        target_d = up_inc_s[FLOOR_W-1:0];
                    end else begin
                        target_d = target_q;
                    end
                    preempt_d = call_ok_s && (bus.call_floor > bus.actual_floor)
                                && (bus.call_floor < target_q);
                end
            end
            S_DOWN: begin
                if (bus.floor_strobe && (bus.actual_floor == target_q)) begin
                    state_d  = S_DOOR;
                    up_req_d = up_m_s & ~act_hot_s;
                    dn_req_d = dn_m_s & ~act_hot_s;
                    dwell_d  = DWELL_LOAD;
                end else begin
                    if (dn_inc_s[FLOOR_W]) begin
                        target_d = dn_inc_s[FLOOR_W-1:0];
                    end else begin
                        target_d = target_q;
                    end
                    preempt_d = call_ok_s && (bus.call_floor < bus.actual_floor)
                                && (bus.call_floor > target_q);
                end
            end
            S_DOOR: begin
                // A call for the open floor is absorbed here and only stretches the dwell.
                up_req_d = up_m_s & ~act_hot_s;
                dn_req_d = dn_m_s & ~act_hot_s;
                if (|(call_hit_s & act_hot_s)) begin
                    dwell_d = DWELL_LOAD;
                end else if (dwell_q != '0) begin
                    dwell_d = dwell_q - DWELL_W'(1);
                end else begin
                    state_d    = dep_state_s;
                    dir_last_d = dep_dir_s;
                    target_d   = dep_tgt_s;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef ELEV_FIRE_RECALL_EN
        if (bus.fire_recall) begin
            up_req_d  = '0;
            dn_req_d  = '0;
            target_d  = '0;
            preempt_d = 1'b0;
            dwell_d   = '0;
            if ((state_q == S_DOWN) ? (bus.floor_strobe && (bus.actual_floor == '0))
                                    : ((state_q != S_UP) && (bus.actual_floor == '0))) begin
                state_d = S_DOOR;
            end else begin
                state_d = S_DOWN;
            end
        end else if (recall_q) begin
            state_d   = S_IDLE;
            up_req_d  = '0;
            dn_req_d  = '0;
            preempt_d = 1'b0;
            dwell_d   = '0;
        end else begin
            recall_d = 1'b0;
        end
`endif
    end

    // State and output registers; commands are decoded from the next state so they leave a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            up_req_q     <= '0;
            dn_req_q     <= '0;
            dir_last_q   <= 1'b1;
            dwell_q      <= '0;
            target_q     <= '0;
            preempt_q    <= 1'b0;
            call_err_q   <= 1'b0;
            motor_up_q   <= 1'b0;
            motor_down_q <= 1'b0;
            door_open_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef ELEV_FIRE_RECALL_EN
            recall_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            up_req_q     <= up_req_d;
            dn_req_q     <= dn_req_d;
            dir_last_q   <= dir_last_d;
            dwell_q      <= dwell_d;
            target_q     <= target_d;
            preempt_q    <= preempt_d;
            call_err_q   <= call_err_d;
            motor_up_q   <= (state_d == S_UP);
            motor_down_q <= (state_d == S_DOWN);
            door_open_q  <= (state_d == S_DOOR);
            busy_q       <= (state_d != S_IDLE) || (|(up_req_d | dn_req_d));
`ifdef ELEV_FIRE_RECALL_EN
            recall_q     <= recall_d;
`endif
        end
    end

    assign bus.target_floor = target_q;
    assign bus.motor_up     = motor_up_q;
    assign bus.motor_down   = motor_down_q;
    assign bus.door_open    = door_open_q;
    assign bus.preempt      = preempt_q;
    assign bus.call_err     = call_err_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed, table-driven bench for elevator_call_scheduler (FLOORS=4, FLOOR_W=3, DWELL=4).
module tb_elevator_call_scheduler;

    localparam int FLOORS  = 4;
    localparam int FLOOR_W = 3;
    localparam int DWELL   = 4;

    typedef struct {
        logic       cv;
        logic [2:0] cf;
        logic       cd;
        logic [2:0] act;
        logic       fs;
        logic [8:0] exp;   // {target[2:0], up, down, door, preempt, err, busy}
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    elevator_call_scheduler_if #(.FLOOR_W(FLOOR_W)) bus();

    elevator_call_scheduler #(
        .FLOORS(FLOORS), .FLOOR_W(FLOOR_W), .DWELL_CYCLES(DWELL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    task automatic add(input logic cv, input logic [2:0] cf, input logic cd,
                       input logic [2:0] act, input logic fs, input logic [2:0] tgt,
                       input logic up, input logic dn, input logic door,
                       input logic pre, input logic err, input logic busy);
        vec_t v;
        v.cv = cv; v.cf = cf; v.cd = cd; v.act = act; v.fs = fs;
        v.exp = {tgt, up, dn, door, pre, err, busy};
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [8:0] exp);
        logic [8:0] got;
        got = {bus.target_floor, bus.motor_up, bus.motor_down, bus.door_open,
               bus.preempt, bus.call_err, bus.busy};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got tgt/up/dn/door/pre/err/busy=%b required %b", name, got, exp);
        end
    endtask

    task automatic step(input logic cv, input logic [2:0] cf, input logic cd,
                        input logic [2:0] act, input logic fs);
        @(negedge clk);
        bus.call_valid   = cv;
        bus.call_floor   = cf;
        bus.call_dir     = cd;
        bus.actual_floor = act;
        bus.floor_strobe = fs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.call_valid = 1'b0; bus.call_floor = 3'd0; bus.call_dir = 1'b0;
        bus.actual_floor = 3'd0; bus.floor_strobe = 1'b0;
`ifdef ELEV_FIRE_RECALL_EN
        bus.fire_recall = 1'b0;
`endif
        //   cv    cf    cd    act   fs  | tgt   up    dn    door  pre   err   busy
        add(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // 0 idle
        add(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); // 1 up call 3
        add(1'b0, 3'd0, 1'b0, 3'd1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); // 2
        add(1'b1, 3'd2, 1'b1, 3'd1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); // 3 preempt
        add(1'b1, 3'd3, 1'b0, 3'd1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); // 4 farther call
        add(1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); // 5 arrive 2
        add(1'b0, 3'd0, 1'b0, 3'd2, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); // 6
        add(1'b0, 3'd0, 1'b0, 3'd2, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); // 7
        add(1'b0, 3'd0, 1'b0, 3'd2, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); // 8
        add(1'b0, 3'd0, 1'b0, 3'd2, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); // 9 continue up
        add(1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); // 10 arrive 3
        add(1'b1, 3'd0, 1'b0, 3'd3, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); // 11 down call 0
        add(1'b0, 3'd0, 1'b0, 3'd3, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); // 12
        add(1'b0, 3'd0, 1'b0, 3'd3, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); // 13
        add(1'b0, 3'd0, 1'b0, 3'd3, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); // 14 reverse
        add(1'b0, 3'd0, 1'b0, 3'd2, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); // 15
        add(1'b1, 3'd5, 1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1); // 16 bad floor
        add(1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); // 17 non-target
        add(1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); // 18 arrive 0
        add(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); // 19 call here
        add(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); // 20
        add(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); // 21
        add(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); // 22 extended
        add(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // 23 idle
        add(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); // 24 flip dir
        add(1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); // 25 preempt
        add(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); // 26 one pulse

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 9'b000_000000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].cv, vq[i].cf, vq[i].cd, vq[i].act, vq[i].fs);
            check($sformatf("vec%0d", i), vq[i].exp);
        end

        // Asynchronous reset while moving up with floors 1 and 2 pending.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 9'b000_000000);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        check("post_reset_idle0", 9'b000_000000);
        step(1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        check("post_reset_idle1", 9'b000_000000);

        // Call at the resting floor opens the door next cycle for exactly DWELL cycles.
        step(1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        check("here_open", 9'b000_001001);
        for (int k = 1; k < DWELL; k++) begin
            step(1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
            check($sformatf("here_dwell%0d", k), 9'b000_001001);
        end
        step(1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        check("here_close", 9'b000_000000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
